// File: rtl/gc_response_decoder.sv
// gc_response_decoder
//
// Receive side of the single-wire controller link. After the poll sender has
// shifted out its command, this block listens for the controller's response:
// it synchronizes the line, times the low phase of every bit, assembles the
// response MSB-first, checks the stop bit and presents the result as a
// registered word with one-cycle valid / error strobes.
//
// Ports:
//   clk        in   system clock
//   rst        in   synchronous active-high reset
//   arm        in   one-cycle pulse: poll sent, start listening
//   line_in    in   raw controller line (idle high), asynchronous
//   busy       out  high whenever the decoder is not idle
//   resp_data  out  last good response, bit RESP_BITS-1 received first
//   resp_valid out  one-cycle pulse, resp_data updated in the same cycle
//   resp_err   out  one-cycle pulse on a failed frame
//   err_code   out  last error: 1 timeout, 2 phase too long, 3 bad stop
//
// Optional build macro RESP_FIELDS_EN adds decoded button / axis / trigger
// outputs plus a format flag, all updated together with resp_valid.
module gc_response_decoder #(
  parameter int CLKS_PER_US = 50,
  parameter int THRESH_US   = 2,
  parameter int MAXPH_US    = 5,
  parameter int TIMEOUT_US  = 200,
  parameter int RESP_BITS   = 64
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 arm,
  input  logic                 line_in,
  output logic                 busy,
  output logic [RESP_BITS-1:0] resp_data,
  output logic                 resp_valid,
  output logic                 resp_err,
  output logic [1:0]           err_code
`ifdef RESP_FIELDS_EN
  ,
  output logic [11:0]          btn,
  output logic [7:0]           joy_x,
  output logic [7:0]           joy_y,
  output logic [7:0]           c_x,
  output logic [7:0]           c_y,
  output logic [7:0]           trig_l,
  output logic [7:0]           trig_r,
  output logic                 fmt_ok
`endif
);

  localparam int THRESH  = THRESH_US * CLKS_PER_US;
  localparam int MAXPH   = MAXPH_US * CLKS_PER_US;
  localparam int TIMEOUT = TIMEOUT_US * CLKS_PER_US;
  localparam int PH_W    = $clog2(MAXPH + 1);
  localparam int TO_W    = $clog2(TIMEOUT + 1);
  localparam int BIT_W   = $clog2(RESP_BITS + 1);

  typedef enum logic [2:0] {
    IDLE, WAIT_START, LOW, HIGH, STOP_WAIT, STOP_LOW, ERR
  } state_e;

  state_e               state_q, state_d;
  logic                 sync1_q, sync2_q, prev_q;
  logic [PH_W-1:0]      ph_cnt_q, ph_cnt_d;
  logic [TO_W-1:0]      to_cnt_q, to_cnt_d;
  logic [BIT_W-1:0]     bit_cnt_q, bit_cnt_d;
  logic [RESP_BITS-1:0] shift_q, shift_d;
  logic [RESP_BITS-1:0] data_q, data_d;
  logic                 valid_q, valid_d;
  logic                 err_q, err_d;
  logic [1:0]           code_q, code_d;

  logic                 fall, rise, phSat, shortLow;
  logic [PH_W:0]        phLen;

  assign fall  = prev_q & ~sync2_q;
  assign rise  = ~prev_q & sync2_q;
  assign phSat = (ph_cnt_q == PH_W'(MAXPH));

  // ph_cnt restarts at 0 in the cycle after an edge, so the length of the
  // phase that ends on the current edge is ph_cnt + 1 cycles.
  assign phLen    = {1'b0, ph_cnt_q} + (PH_W + 1)'(1);
  assign shortLow = (phLen < (PH_W + 1)'(THRESH));

  // Phase counter clears on any edge or arm and saturates; the timeout
  // counter only runs while waiting for the first falling edge.
  always_comb begin
    ph_cnt_d = ph_cnt_q;
    to_cnt_d = to_cnt_q;
    if (arm || fall || rise) begin
      ph_cnt_d = '0;
    end else if (!phSat) begin
      ph_cnt_d = ph_cnt_q + PH_W'(1);
    end
    if (arm) begin
      to_cnt_d = '0;
    end else if (state_q == WAIT_START && to_cnt_q != TO_W'(TIMEOUT)) begin
      to_cnt_d = to_cnt_q + TO_W'(1);
    end
  end

  // Frame FSM next-state logic. arm overrides everything so that a restart
  // discards any partial frame and the strobe it might have produced.
  always_comb begin
    state_d   = state_q;
    bit_cnt_d = bit_cnt_q;
    shift_d   = shift_q;
    data_d    = data_q;
    valid_d   = 1'b0;
    code_d    = code_q;
    case (state_q)
      IDLE: ;
      WAIT_START: begin
        if (fall) begin
          state_d = LOW;
        end else if (to_cnt_q == TO_W'(TIMEOUT)) begin
          state_d = ERR;
          code_d  = 2'd1;
        end
      end
      LOW: begin
        if (rise) begin
          shift_d   = {shift_q[RESP_BITS-2:0], shortLow};
          bit_cnt_d = bit_cnt_q + BIT_W'(1);
          state_d   = (bit_cnt_q == BIT_W'(RESP_BITS - 1)) ? STOP_WAIT : HIGH;
        end else if (phSat) begin
          state_d = ERR;
          code_d  = 2'd2;
        end
      end
      HIGH, STOP_WAIT: begin
        if (fall) begin
          state_d = (state_q == HIGH) ? LOW : STOP_LOW;
        end else if (phSat) begin
          state_d = ERR;
          code_d  = 2'd2;
        end
      end
      STOP_LOW: begin
        if (rise) begin
          if (shortLow) begin
            data_d  = shift_q;
            valid_d = 1'b1;
            state_d = IDLE;
          end else begin
            state_d = ERR;
            code_d  = 2'd3;
          end
        end else if (phSat) begin
          state_d = ERR;
          code_d  = 2'd2;
        end
      end
      ERR:     state_d = IDLE;
      default: state_d = IDLE;
    endcase
    if (arm) begin
      state_d   = WAIT_START;
      bit_cnt_d = '0;
      shift_d   = '0;
      data_d    = data_q;
      valid_d   = 1'b0;
      code_d    = code_q;
    end
    err_d = (state_d == ERR);
  end

  // State, counters, synchronizer and registered outputs. The synchronizer
  // presets to 1 so the idle-high line produces no edge out of reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      sync1_q   <= 1'b1;
      sync2_q   <= 1'b1;
      prev_q    <= 1'b1;
      state_q   <= IDLE;
      ph_cnt_q  <= '0;
      to_cnt_q  <= '0;
      bit_cnt_q <= '0;
      shift_q   <= '0;
      data_q    <= '0;
      valid_q   <= 1'b0;
      err_q     <= 1'b0;
      code_q    <= 2'd0;
    end else begin
      sync1_q   <= line_in;
      sync2_q   <= sync1_q;
      prev_q    <= sync2_q;
      state_q   <= state_d;
      ph_cnt_q  <= ph_cnt_d;
      to_cnt_q  <= to_cnt_d;
      bit_cnt_q <= bit_cnt_d;
      shift_q   <= shift_d;
      data_q    <= data_d;
      valid_q   <= valid_d;
      err_q     <= err_d;
      code_q    <= code_d;
    end
  end

  assign busy       = (state_q != IDLE);
  assign resp_data  = data_q;
  assign resp_valid = valid_q;
  assign resp_err   = err_q;
  assign err_code   = code_q;

`ifdef RESP_FIELDS_EN
  // Field split of a good response, loaded in the same cycle as resp_data.
  always_ff @(posedge clk) begin
    if (rst) begin
      btn    <= '0;
      joy_x  <= '0;
      joy_y  <= '0;
      c_x    <= '0;
      c_y    <= '0;
      trig_l <= '0;
      trig_r <= '0;
      fmt_ok <= 1'b0;
    end else if (valid_d) begin
      btn    <= {shift_q[60:56], shift_q[54:48]};
      joy_x  <= shift_q[47:40];
      joy_y  <= shift_q[39:32];
      c_x    <= shift_q[31:24];
      c_y    <= shift_q[23:16];
      trig_l <= shift_q[15:8];
      trig_r <= shift_q[7:0];
      fmt_ok <= (shift_q[63:61] == 3'b000) && shift_q[55];
    end
  end
`endif

endmodule

// File: tb/tb_gc_response_decoder.sv
// Self-checking bench for gc_response_decoder: drives controller response
// frames onto line_in and compares every strobe against a queue of expected
// results pushed by each scenario before it drives stimulus.
module tb_gc_response_decoder;

  logic        clk = 1'b0;
  logic        rst;
  logic        arm;
  logic        line_in;
  logic        busy;
  logic [63:0] resp_data;
  logic        resp_valid;
  logic        resp_err;
  logic [1:0]  err_code;
`ifdef RESP_FIELDS_EN
  logic [11:0] btn;
  logic [7:0]  joy_x, joy_y, c_x, c_y, trig_l, trig_r;
  logic        fmt_ok;
`endif

  typedef struct {
    logic        isErr;
    logic [63:0] data;
    logic [1:0]  code;
  } exp_t;

  exp_t        sbQ[$];
  int          nAsserts = 0;
  int          nFail = 0;
  int          cycleCnt = 0;
  int          lastStrobeCycle = -1;
  int          lastRiseCycle = 0;
  logic [63:0] expData = '0;
  logic [1:0]  expCode = 2'd0;

  gc_response_decoder #(
    .CLKS_PER_US(50), .THRESH_US(2), .MAXPH_US(5), .TIMEOUT_US(200), .RESP_BITS(64)
  ) dut (
    .clk(clk), .rst(rst), .arm(arm), .line_in(line_in), .busy(busy),
    .resp_data(resp_data), .resp_valid(resp_valid), .resp_err(resp_err),
    .err_code(err_code)
`ifdef RESP_FIELDS_EN
    , .btn(btn), .joy_x(joy_x), .joy_y(joy_y), .c_x(c_x), .c_y(c_y),
    .trig_l(trig_l), .trig_r(trig_r), .fmt_ok(fmt_ok)
`endif
  );

  always #5 clk = ~clk;

  always @(posedge clk) cycleCnt++;

  // Scoreboard monitor: every strobe must match the oldest expected entry.
  always @(negedge clk) begin
    exp_t e;
    if (resp_valid || resp_err) begin
      lastStrobeCycle = cycleCnt;
      nAsserts++;
      if (resp_valid && resp_err) begin
        nFail++;
        $display("[TB] FAIL strobe_overlap: valid=%b err=%b, required not both", resp_valid, resp_err);
      end
      nAsserts++;
      if (sbQ.size() == 0) begin
        nFail++;
        $display("[TB] FAIL unexpected_strobe: valid=%b err=%b code=%0d, required no strobe", resp_valid, resp_err, err_code);
      end else begin
        e = sbQ.pop_front();
        if (resp_err !== e.isErr) begin
          nFail++;
          $display("[TB] FAIL strobe_kind: resp_err=%b, required %b", resp_err, e.isErr);
        end
        nAsserts++;
        if (resp_data !== e.data) begin
          nFail++;
          $display("[TB] FAIL resp_data: got %h, required %h", resp_data, e.data);
        end
        nAsserts++;
        if (err_code !== e.code) begin
          nFail++;
          $display("[TB] FAIL err_code: got %0d, required %0d", err_code, e.code);
        end
      end
    end
  end

  initial begin
    #950_000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic pushExp(input logic isErr, input logic [63:0] d, input logic [1:0] c);
    exp_t e;
    e.isErr = isErr;
    e.data  = d;
    e.code  = c;
    sbQ.push_back(e);
  endtask

  task automatic pulseArm();
    @(negedge clk) arm = 1'b1;
    @(negedge clk) arm = 1'b0;
  endtask

  // Called on a negedge; leaves the line low lowLen cycles then high highLen.
  task automatic sendBit(input int lowLen, input int highLen);
    line_in = 1'b0;
    repeat (lowLen) @(negedge clk);
    line_in = 1'b1;
    lastRiseCycle = cycleCnt;
    repeat (highLen) @(negedge clk);
  endtask

  task automatic sendNom(input logic b);
    if (b) sendBit(50, 150);
    else   sendBit(150, 50);
  endtask

  // Sends the top nBits of d MSB-first; stopLow of 0 means no stop bit.
  task automatic sendFrame(input logic [63:0] d, input int nBits, input int stopLow);
    for (int i = 63; i >= 64 - nBits; i--) sendNom(d[i]);
    if (stopLow > 0) begin
      line_in = 1'b0;
      repeat (stopLow) @(negedge clk);
      line_in = 1'b1;
    end
  endtask

  task automatic waitDrain(input int budget, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < budget; i++) begin
      if (sbQ.size() == 0) break;
      @(negedge clk);
    end
    if (sbQ.size() == 0) ok = 1'b1;
  endtask

  task automatic test_reset();
    rst = 1'b1; arm = 1'b0; line_in = 1'b1;
    repeat (3) @(negedge clk);
    nAsserts++;
    if ({busy, resp_valid, resp_err} !== 3'b000) begin
      nFail++;
      $display("[TB] FAIL reset_flags: busy/valid/err=%b, required 000", {busy, resp_valid, resp_err});
    end
    nAsserts++;
    if (resp_data !== 64'd0) begin
      nFail++;
      $display("[TB] FAIL reset_data: got %h, required 0", resp_data);
    end
    nAsserts++;
    if (err_code !== 2'd0) begin
      nFail++;
      $display("[TB] FAIL reset_code: got %0d, required 0", err_code);
    end
    rst = 1'b0;
    repeat (5) @(negedge clk);
    nAsserts++;
    if (busy !== 1'b0) begin
      nFail++;
      $display("[TB] FAIL idle_after_reset: busy=%b, required 0", busy);
    end
  endtask

  task automatic test_nominal();
    bit ok;
    logic [63:0] d = 64'h0080_8080_8080_0000;
    pushExp(1'b0, d, expCode);
    pulseArm();
    nAsserts++;
    if (busy !== 1'b1) begin
      nFail++;
      $display("[TB] FAIL busy_after_arm: busy=%b, required 1", busy);
    end
    sendFrame(d, 64, 50);
    waitDrain(50, ok);
    nAsserts++;
    if (!ok) begin
      nFail++;
      $display("[TB] FAIL nominal_done: pending=%0d, required 0", sbQ.size());
    end
    @(negedge clk);
    nAsserts++;
    if (busy !== 1'b0) begin
      nFail++;
      $display("[TB] FAIL nominal_busy: busy=%b, required 0", busy);
    end
    expData = d;
    repeat (300) @(negedge clk);
  endtask

  task automatic test_timeout();
    bit ok;
    int startCyc;
    pushExp(1'b1, expData, 2'd1);
    pulseArm();
    startCyc = cycleCnt;
    waitDrain(10100, ok);
    nAsserts++;
    if (!ok) begin
      nFail++;
      $display("[TB] FAIL timeout_done: pending=%0d, required 0", sbQ.size());
    end
    nAsserts++;
    if (lastStrobeCycle - startCyc < 9995 || lastStrobeCycle - startCyc > 10015) begin
      nFail++;
      $display("[TB] FAIL timeout_delay: got %0d clk, required 9995..10015", lastStrobeCycle - startCyc);
    end
    expCode = 2'd1;
    repeat (20) @(negedge clk);
  endtask

  task automatic test_truncation();
    bit ok;
    pushExp(1'b1, expData, 2'd2);
    pulseArm();
    sendFrame(64'hC3A5_0000_0000_0000, 20, 0);
    waitDrain(1000, ok);
    nAsserts++;
    if (!ok) begin
      nFail++;
      $display("[TB] FAIL trunc_done: pending=%0d, required 0", sbQ.size());
    end
    nAsserts++;
    if (lastStrobeCycle - lastRiseCycle < 245 || lastStrobeCycle - lastRiseCycle > 265) begin
      nFail++;
      $display("[TB] FAIL trunc_delay: got %0d clk of high, required 245..265", lastStrobeCycle - lastRiseCycle);
    end
    expCode = 2'd2;
    repeat (20) @(negedge clk);
  endtask

  // 99-clk low must decode as 1 and 100-clk low as 0 in an all-ones frame.
  task automatic test_threshold();
    bit ok;
    logic [63:0] d = 64'hFFFF_FFFF_FFEF_FFFF;
    pushExp(1'b0, d, expCode);
    pulseArm();
    for (int i = 63; i >= 0; i--) begin
      if (i == 40)      sendBit(99, 101);
      else if (i == 20) sendBit(100, 100);
      else              sendNom(1'b1);
    end
    line_in = 1'b0;
    repeat (50) @(negedge clk);
    line_in = 1'b1;
    waitDrain(50, ok);
    nAsserts++;
    if (!ok) begin
      nFail++;
      $display("[TB] FAIL threshold_done: pending=%0d, required 0", sbQ.size());
    end
    expData = d;
    repeat (300) @(negedge clk);
  endtask

  task automatic test_bad_stop();
    bit ok;
    pushExp(1'b1, expData, 2'd3);
    pulseArm();
    sendFrame(64'h0080_8080_8080_0000, 64, 150);
    waitDrain(50, ok);
    nAsserts++;
    if (!ok) begin
      nFail++;
      $display("[TB] FAIL badstop_done: pending=%0d, required 0", sbQ.size());
    end
    expCode = 2'd3;
    repeat (300) @(negedge clk);
  endtask

  task automatic test_reset_mid();
    pulseArm();
    sendFrame(64'h0123_4567_89AB_CDEF, 30, 0);
    line_in = 1'b0;
    repeat (20) @(negedge clk);
    rst = 1'b1;
    repeat (2) @(negedge clk);
    nAsserts++;
    if ({busy, resp_valid, resp_err, err_code} !== 5'b0) begin
      nFail++;
      $display("[TB] FAIL midreset_flags: busy/valid/err/code=%b, required 00000", {busy, resp_valid, resp_err, err_code});
    end
    nAsserts++;
    if (resp_data !== 64'd0) begin
      nFail++;
      $display("[TB] FAIL midreset_data: got %h, required 0", resp_data);
    end
    line_in = 1'b1;
    rst = 1'b0;
    repeat (300) @(negedge clk);
    nAsserts++;
    if (busy !== 1'b0 || err_code !== 2'd0) begin
      nFail++;
      $display("[TB] FAIL midreset_after: busy=%b code=%0d, required 0/0", busy, err_code);
    end
    expData = '0;
    expCode = 2'd0;
  endtask

  task automatic test_back_to_back();
    bit ok;
    logic [63:0] d = 64'h1234_5678_9ABC_DEF0;
    pulseArm();
    sendFrame(64'hA5A5_A5A5_A5A5_A5A5, 10, 0);
    pushExp(1'b0, d, expCode);
    pulseArm();
    sendFrame(d, 64, 50);
    waitDrain(50, ok);
    nAsserts++;
    if (!ok) begin
      nFail++;
      $display("[TB] FAIL rearm_done: pending=%0d, required 0", sbQ.size());
    end
    @(negedge clk);
    nAsserts++;
    if (busy !== 1'b0) begin
      nFail++;
      $display("[TB] FAIL rearm_busy: busy=%b, required 0", busy);
    end
    repeat (300) @(negedge clk);
  endtask

  initial begin
    test_reset();
    test_nominal();
    test_timeout();
    test_truncation();
    test_threshold();
    test_bad_stop();
    test_reset_mid();
    test_back_to_back();
    nAsserts++;
    if (sbQ.size() != 0) begin
      nFail++;
      $display("[TB] FAIL leftover_expected: pending=%0d, required 0", sbQ.size());
    end
    $display("End of test - %0d assertions evaluated, %0d failures", nAsserts, nFail);
    $finish;
  end

endmodule
